cc_sequencer: RTL and testbench

- Owns the Y86-64 condition-code register {ZF,SF,OF} and sequences its updates from the execute stage.
- Computes new flags from the ALU operands and result for OPq, and gates the write on stall and on downstream exception status.
- Evaluates the branch/cmov condition from the current CC.
- Freezes CC after any memory- or writeback-stage exception until reset, and counts committed CC writes for debug.

---
 rtl/cc_sequencer.sv | 167 ++++++++++++++++
 tb/tb_cc_sequencer.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cc_sequencer.sv
// cc_sequencer
// Owns the Y86-64 condition-code register {ZF,SF,OF}. It computes new
// flags for OPq instructions in the execute stage and writes them unless
// the stage is stalled or a downstream stage reports an exception. Any
// memory- or writeback-stage exception freezes the register until reset.
// It also evaluates the jXX/cmovXX condition from the registered flags and
// keeps a saturating count of committed flag writes for debug.
//
// Ports:
//   clk       system clock, all state changes on the rising edge
//   reset     synchronous active-low reset
//   e_valid   execute stage holds a real instruction (0 = bubble)
//   e_icode   execute-stage icode (OPq=6, cmovXX/rrmovq=2, jXX=7)
//   e_ifun    execute-stage ifun
//   stall_e   execute stage stalled this cycle
//   alu_a     ALU operand valA
//   alu_b     ALU operand valB
//   alu_res   ALU result valE
//   m_stat    memory-stage status (0 AOK, 1 HLT, 2 ADR, 3 INS)
//   w_stat    writeback-stage status, same encoding
//   cc        registered flags {ZF,SF,OF}
//   e_cnd     combinational condition result for the execute instruction
//   cc_wr     registered pulse, high the cycle after a committed write
//   frozen    high while the register is frozen by an exception
//   wr_count  saturating count of committed flag writes
module cc_sequencer #(
  parameter int W     = 64,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             e_valid,
  input  logic [3:0]       e_icode,
  input  logic [3:0]       e_ifun,
  input  logic             stall_e,
  input  logic [W-1:0]     alu_a,
  input  logic [W-1:0]     alu_b,
  input  logic [W-1:0]     alu_res,
  input  logic [1:0]       m_stat,
  input  logic [1:0]       w_stat,
  output logic [2:0]       cc,
  output logic             e_cnd,
  output logic             cc_wr,
  output logic             frozen,
  output logic [CNT_W-1:0] wr_count
);

  typedef enum logic {
    RUN    = 1'b0,
    FROZEN = 1'b1
  } state_t;

  localparam logic [3:0]       ICODE_OPQ  = 4'd6;
  localparam logic [3:0]       ICODE_CMOV = 4'd2;
  localparam logic [3:0]       ICODE_JXX  = 4'd7;
  localparam logic [2:0]       CC_RESET   = 3'b100;
  localparam logic [CNT_W-1:0] CNT_MAX    = '1;
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

  state_t     state;
  logic       exc;
  logic       upd;
  logic       new_zf;
  logic       new_sf;
  logic       new_of;
  logic       sign_a;
  logic       sign_b;
  logic       sign_r;
  logic       cur_zf;
  logic       cur_sf;
  logic       cur_of;
  logic       unused_operand_bits;

  // Only the sign bits of the operands feed the overflow logic; the rest
  // of each operand is folded here so the intent is explicit.
  assign unused_operand_bits = ^{alu_a[W-2:0], alu_b[W-2:0]};

  assign sign_a = alu_a[W-1];
  assign sign_b = alu_b[W-1];
  assign sign_r = alu_res[W-1];

  assign cur_zf = cc[2];
  assign cur_sf = cc[1];
  assign cur_of = cc[0];

  // Any non-AOK status further down the pipe means the instruction in E
  // must not be allowed to change architectural flags.
  assign exc = (m_stat != 2'd0) | (w_stat != 2'd0);

  // A write is committed only for a real, unstalled OPq with a defined
  // ifun; unknown ALU functions are silently ignored rather than guessed.
  assign upd = e_valid & (e_icode == ICODE_OPQ) & ~stall_e & (e_ifun <= 4'd3);

  assign frozen = (state == FROZEN);

  // Candidate flags from the execute-stage result. Overflow is derived from
  // the operand and result signs: addition overflows when both operands
  // share a sign the result lacks, subtraction (b-a) when the operands
  // differ in sign and the result departs from b. Logical ops never overflow.
  always_comb begin
    new_zf = (alu_res == '0);
    new_sf = sign_r;
    new_of = 1'b0;
    case (e_ifun)
      4'd0:    new_of = (sign_a == sign_b) & (sign_r != sign_a);
      4'd1:    new_of = (sign_a != sign_b) & (sign_r != sign_b);
      default: new_of = 1'b0;
    endcase
  end

  // Condition evaluation looks only at the registered flags, so an OPq
  // sitting in E never influences its own cycle's condition. Non-branch,
  // non-move instructions and bubbles always report false.
  always_comb begin
    e_cnd = 1'b0;
    if (e_valid && ((e_icode == ICODE_CMOV) || (e_icode == ICODE_JXX))) begin
      case (e_ifun)
        4'd0:    e_cnd = 1'b1;
        4'd1:    e_cnd = (cur_sf ^ cur_of) | cur_zf;
        4'd2:    e_cnd = cur_sf ^ cur_of;
        4'd3:    e_cnd = cur_zf;
        4'd4:    e_cnd = ~cur_zf;
        4'd5:    e_cnd = ~(cur_sf ^ cur_of);
        4'd6:    e_cnd = ~(cur_sf ^ cur_of) & ~cur_zf;
        default: e_cnd = 1'b0;
      endcase
    end
  end

  // Sequencer: in RUN an exception wins over any pending write and moves to
  // FROZEN, otherwise a committed update loads the flags, raises the write
  // pulse and bumps the saturating counter. FROZEN holds everything and is
  // left only through reset, which beats every other input.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state    <= RUN;
      cc       <= CC_RESET;
      cc_wr    <= 1'b0;
      wr_count <= '0;
    end else begin
      case (state)
        RUN: begin
          if (exc) begin
            state <= FROZEN;
            cc_wr <= 1'b0;
          end else if (upd) begin
            cc    <= {new_zf, new_sf, new_of};
            cc_wr <= 1'b1;
            if (wr_count != CNT_MAX) begin
              wr_count <= wr_count + CNT_ONE;
            end
          end else begin
            cc_wr <= 1'b0;
          end
        end
        FROZEN: begin
          cc_wr <= 1'b0;
        end
        default: begin
          state <= FROZEN;
          cc_wr <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cc_sequencer.sv
// tb_cc_sequencer
// Self-checking bench for cc_sequencer with a short counter (CNT_W=3) so
// saturation is reachable. A behavioural model tracks the flags from signed
// arithmetic on the operands and is compared against the DUT on every
// falling edge; directed steps add literal expectations on top.
module tb_cc_sequencer;

  localparam int W       = 64;
  localparam int CNT_W   = 3;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic             clk;
  logic             reset;
  logic             e_valid;
  logic [3:0]       e_icode;
  logic [3:0]       e_ifun;
  logic             stall_e;
  logic [W-1:0]     alu_a;
  logic [W-1:0]     alu_b;
  logic [W-1:0]     alu_res;
  logic [1:0]       m_stat;
  logic [1:0]       w_stat;
  logic [2:0]       cc;
  logic             e_cnd;
  logic             cc_wr;
  logic             frozen;
  logic [CNT_W-1:0] wr_count;

  int checks   = 0;
  int failures = 0;

  logic       modelValid = 1'b0;
  logic       mZf, mSf, mOf;
  logic       mFrozen;
  logic       mWr;
  int         mCount;

  cc_sequencer #(.W(W), .CNT_W(CNT_W)) dut (
    .clk      (clk),
    .reset    (reset),
    .e_valid  (e_valid),
    .e_icode  (e_icode),
    .e_ifun   (e_ifun),
    .stall_e  (stall_e),
    .alu_a    (alu_a),
    .alu_b    (alu_b),
    .alu_res  (alu_res),
    .m_stat   (m_stat),
    .w_stat   (w_stat),
    .cc       (cc),
    .e_cnd    (e_cnd),
    .cc_wr    (cc_wr),
    .frozen   (frozen),
    .wr_count (wr_count)
  );

  // Free-running clock, period 10.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison primitive: every check in the bench goes through it.
  task automatic cmp(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Flags the architecture defines for an OPq, derived from the operands by
  // doing the arithmetic wide enough that signed overflow is visible as a
  // disagreement between the two top bits of the extended result.
  function automatic logic [2:0] modelFlags(input logic [3:0] fn, input logic [63:0] a,
                                            input logic [63:0] b);
    logic [65:0] wide;
    logic [63:0] r;
    logic        ovf;
    wide = '0;
    r    = '0;
    ovf  = 1'b0;
    case (fn)
      4'd0: begin
        wide = {{2{b[63]}}, b} + {{2{a[63]}}, a};
        r    = wide[63:0];
        ovf  = wide[64] != wide[63];
      end
      4'd1: begin
        wide = {{2{b[63]}}, b} - {{2{a[63]}}, a};
        r    = wide[63:0];
        ovf  = wide[64] != wide[63];
      end
      4'd2: r = a & b;
      default: r = a ^ b;
    endcase
    return {r == 64'd0, r[63], ovf};
  endfunction

  // Branch semantics in terms of signed comparison of the last OPq result.
  function automatic logic modelCond(input logic v, input logic [3:0] ic, input logic [3:0] fn,
                                     input logic zf, input logic sf, input logic of);
    logic isLess;
    if (!v || !(ic == 4'd2 || ic == 4'd7)) return 1'b0;
    isLess = (sf != of);
    case (fn)
      4'd0: return 1'b1;
      4'd1: return isLess || zf;
      4'd2: return isLess;
      4'd3: return zf;
      4'd4: return !zf;
      4'd5: return !isLess;
      4'd6: return !isLess && !zf;
      default: return 1'b0;
    endcase
  endfunction

  // Reference model, advanced on each rising edge from the inputs the DUT sees.
  always @(posedge clk) begin
    if (!reset) begin
      {mZf, mSf, mOf} = 3'b100;
      mFrozen    = 1'b0;
      mWr        = 1'b0;
      mCount     = 0;
      modelValid = 1'b1;
    end else if (modelValid) begin
      if (mFrozen) begin
        mWr = 1'b0;
      end else if (m_stat != 2'd0 || w_stat != 2'd0) begin
        mFrozen = 1'b1;
        mWr     = 1'b0;
      end else if (e_valid && e_icode == 4'd6 && !stall_e && e_ifun < 4'd4) begin
        {mZf, mSf, mOf} = modelFlags(e_ifun, alu_a, alu_b);
        mWr    = 1'b1;
        mCount = (mCount < CNT_MAX) ? mCount + 1 : CNT_MAX;
      end else begin
        mWr = 1'b0;
      end
    end
  end

  // Compares every DUT output against the model mid-cycle.
  task automatic checkOutput();
    cmp("cc", cc, {mZf, mSf, mOf});
    cmp("cc_wr", cc_wr, mWr);
    cmp("frozen", frozen, mFrozen);
    cmp("wr_count", wr_count, mCount);
    cmp("e_cnd", e_cnd, modelCond(e_valid, e_icode, e_ifun, mZf, mSf, mOf));
  endtask

  always @(negedge clk) begin
    if (modelValid) checkOutput();
  end

  task automatic applyStimulus(input logic rst, input logic v, input logic [3:0] ic,
                               input logic [3:0] fn, input logic st, input logic [63:0] a,
                               input logic [63:0] b, input logic [63:0] r,
                               input logic [1:0] ms, input logic [1:0] ws);
    reset   = rst;
    e_valid = v;
    e_icode = ic;
    e_ifun  = fn;
    stall_e = st;
    alu_a   = a;
    alu_b   = b;
    alu_res = r;
    m_stat  = ms;
    w_stat  = ws;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic opq(input logic [3:0] fn, input logic [63:0] a, input logic [63:0] b,
                     input logic [63:0] r);
    applyStimulus(1'b1, 1'b1, 4'd6, fn, 1'b0, a, b, r, 2'd0, 2'd0);
  endtask

  task automatic branch(input logic [3:0] ic, input logic [3:0] fn);
    applyStimulus(1'b1, 1'b1, ic, fn, 1'b0, '0, '0, '0, 2'd0, 2'd0);
  endtask

  initial begin
    applyStimulus(1'b0, 1'b0, 4'd0, 4'd0, 1'b0, '0, '0, '0, 2'd0, 2'd0);
    tick();
    tick();
    cmp("reset_cc", cc, 3'b100);
    cmp("reset_count", wr_count, 0);
    cmp("reset_frozen", frozen, 1'b0);
    cmp("reset_wr", cc_wr, 1'b0);

    // addq 1 + -1 = 0
    opq(4'd0, 64'd1, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0);
    tick();
    cmp("add_zero_cc", cc, 3'b100);
    cmp("add_zero_wr", cc_wr, 1'b1);
    cmp("add_zero_count", wr_count, 1);

    // addq positive overflow
    opq(4'd0, 64'h7FFF_FFFF_FFFF_FFFF, 64'h7FFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFE);
    tick();
    cmp("add_ovf_cc", cc, 3'b011);
    cmp("add_ovf_model_pin", {mZf, mSf, mOf}, 3'b011);
    cmp("add_ovf_wr", cc_wr, 1'b1);
    branch(4'd7, 4'd2);
    cmp("jl_after_ovf", e_cnd, 1'b0);
    branch(4'd7, 4'd1);
    cmp("jle_after_ovf", e_cnd, 1'b0);
    branch(4'd7, 4'd4);
    cmp("jne_after_ovf", e_cnd, 1'b1);
    tick();
    cmp("branch_no_wr", cc_wr, 1'b0);

    // subq min - 1 overflows
    opq(4'd1, 64'd1, 64'h8000_0000_0000_0000, 64'h7FFF_FFFF_FFFF_FFFF);
    cmp("opq_own_cycle_cnd", e_cnd, 1'b0);
    tick();
    cmp("sub_ovf_cc", cc, 3'b001);
    cmp("sub_ovf_model_pin", {mZf, mSf, mOf}, 3'b001);
    branch(4'd2, 4'd5);
    cmp("cmovge_after_sub", e_cnd, 1'b0);
    tick();

    // Stalled andq: held for three edges, then a single write.
    applyStimulus(1'b1, 1'b1, 4'd6, 4'd2, 1'b1, 64'hF0, 64'h0F, 64'd0, 2'd0, 2'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      cmp("stall_hold_cc", cc, 3'b001);
      cmp("stall_hold_wr", cc_wr, 1'b0);
    end
    opq(4'd2, 64'hF0, 64'h0F, 64'd0);
    tick();
    cmp("stall_release_cc", cc, 3'b100);
    cmp("stall_release_count", wr_count, 4);

    // Bubble carrying an OPq icode.
    applyStimulus(1'b1, 1'b0, 4'd6, 4'd0, 1'b0, 64'd5, 64'd5, 64'd10, 2'd0, 2'd0);
    tick();
    cmp("bubble_no_wr", cc_wr, 1'b0);
    cmp("bubble_count", wr_count, 4);

    // Back-to-back xorq then subq.
    opq(4'd3, 64'd1, 64'd3, 64'd2);
    tick();
    cmp("b2b_first_wr", cc_wr, 1'b1);
    cmp("b2b_first_cc", cc, 3'b000);
    opq(4'd1, 64'd2, 64'd1, 64'hFFFF_FFFF_FFFF_FFFF);
    tick();
    cmp("b2b_second_wr", cc_wr, 1'b1);
    cmp("b2b_second_cc", cc, 3'b010);
    cmp("b2b_count", wr_count, 6);

    // Sweep every branch function against the current flags.
    for (int f = 0; f < 16; f++) begin
      branch(4'd7, 4'(f));
      tick();
    end

    // Exception alongside an OPq: no write, freeze.
    applyStimulus(1'b1, 1'b1, 4'd6, 4'd0, 1'b0, 64'd1, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0,
                  2'd2, 2'd0);
    tick();
    cmp("exc_frozen", frozen, 1'b1);
    cmp("exc_cc_held", cc, 3'b010);
    cmp("exc_no_wr", cc_wr, 1'b0);
    opq(4'd0, 64'd1, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0);
    tick();
    tick();
    cmp("frozen_cc_held", cc, 3'b010);
    cmp("frozen_count_held", wr_count, 6);
    cmp("frozen_still", frozen, 1'b1);
    branch(4'd7, 4'd2);
    cmp("frozen_jl", e_cnd, 1'b1);

    // Reset while frozen and stalled.
    applyStimulus(1'b0, 1'b1, 4'd6, 4'd0, 1'b1, 64'd3, 64'd3, 64'd6, 2'd3, 2'd1);
    tick();
    cmp("unfreeze_cc", cc, 3'b100);
    cmp("unfreeze_frozen", frozen, 1'b0);
    cmp("unfreeze_count", wr_count, 0);

    // Saturation: eight writes against a 3-bit counter.
    for (int i = 0; i < 8; i++) begin
      opq(4'd0, 64'(i), 64'd1, 64'(i + 1));
      tick();
    end
    cmp("sat_count", wr_count, 7);
    cmp("sat_wr", cc_wr, 1'b1);
    branch(4'd7, 4'd7);
    cmp("jxx_ifun7", e_cnd, 1'b0);
    tick();
    opq(4'd5, 64'd0, 64'd0, 64'd0);
    tick();
    cmp("bad_ifun_no_wr", cc_wr, 1'b0);
    cmp("bad_ifun_cc", cc, 3'b000);
    branch(4'd4, 4'd0);
    cmp("non_branch_icode", e_cnd, 1'b0);
    branch(4'd2, 4'd0);
    cmp("cmov_always", e_cnd, 1'b1);
    tick();

    // Writeback-stage exception also freezes.
    applyStimulus(1'b1, 1'b0, 4'd0, 4'd0, 1'b0, '0, '0, '0, 2'd0, 2'd3);
    tick();
    cmp("wstat_frozen", frozen, 1'b1);
    applyStimulus(1'b1, 1'b0, 4'd0, 4'd0, 1'b0, '0, '0, '0, 2'd0, 2'd0);
    tick();
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
